// File: rtl/hcsr04_echo_emulator_if.sv
// Trigger/echo bundle between an HC-SR04 driver (master) and the sensor emulator (slave).
// The driver owns trigger and programmed distance; the emulator owns echo and status pulses.
interface hcsr04_echo_emulator_if;
   logic        iTrig;
   logic [15:0] iDistanceCm;
   logic        oEcho;
   logic        oBusy;
   logic        oTrigAccepted;
   logic        oTrigRejected;

   modport master (
      output iTrig,
      output iDistanceCm,
      input  oEcho,
      input  oBusy,
      input  oTrigAccepted,
      input  oTrigRejected
   );

   modport slave (
      input  iTrig,
      input  iDistanceCm,
      output oEcho,
      output oBusy,
      output oTrigAccepted,
      output oTrigRejected
   );
endinterface

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: qualifies trigger width, waits the burst delay, drives a 58 us/cm echo.
// Trigger pin fall to oTrigAccepted is 3 cycles; triggers outside IDLE are ignored, never queued.

module sync_2ff (
   input  logic iClk,
   input  logic iRstn,
   input  logic iD,
   output logic oQ
);
   logic meta_q;
   logic sync_q;

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= iD;
         sync_q <= meta_q;
      end
   end

   assign oQ = sync_q;
endmodule

module hcsr04_echo_emulator #(
   parameter int P_SYS_CLK_HZ  = 100_000_000,
   parameter int P_MIN_TRIG_US = 10,
   parameter int P_BURST_US    = 200,
   parameter int P_MAX_CM      = 400,
   parameter int P_NO_ECHO_US  = 38_000,
   parameter int P_HOLDOFF_US  = 10_000
) (
   input  logic                         iClk,
   input  logic                         iRstn,
   hcsr04_echo_emulator_if.slave        bus
);
   localparam int          LP_1_US       = P_SYS_CLK_HZ / 1_000_000;
   localparam logic [23:0] LP_TRIG_MIN   = 24'(P_MIN_TRIG_US * LP_1_US);
   localparam logic [23:0] LP_BURST      = 24'(P_BURST_US * LP_1_US);
   localparam logic [23:0] LP_HOLDOFF    = 24'(P_HOLDOFF_US * LP_1_US);
   localparam logic [31:0] LP_NO_ECHO    = 32'(P_NO_ECHO_US * LP_1_US);
   localparam logic [31:0] LP_CYC_PER_CM = 32'(58 * LP_1_US);
   localparam logic [15:0] LP_MAX_CM     = 16'(P_MAX_CM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST_DELAY,
      S_ECHO_HIGH,
      S_HOLDOFF
   } state_t;

   state_t      state_q;
   logic [23:0] width_q;
   logic [23:0] cnt_q;
   logic [31:0] len_q;
   logic        trig_prev_q;
   logic        echo_q;
   logic        busy_q;
   logic        acc_q;
   logic        rej_q;

   logic        trig_s;
   logic        trig_fall;
   logic [23:0] width_d;
   logic [31:0] len_d;

   sync_2ff u_trig_sync (
      .iClk  (iClk),
      .iRstn (iRstn),
      .iD    (bus.iTrig),
      .oQ    (trig_s)
   );

   assign trig_fall = trig_prev_q & ~trig_s;

   always_comb begin
      width_d = width_q;
      if (width_q != LP_TRIG_MIN) begin
         width_d = width_q + 24'd1;
      end
   end

   // Zero and out-of-range distances both report "no object".
   always_comb begin
      len_d = LP_NO_ECHO;
      if ((bus.iDistanceCm != 16'd0) && (bus.iDistanceCm <= LP_MAX_CM)) begin
         len_d = {16'd0, bus.iDistanceCm} * LP_CYC_PER_CM;
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_q     <= S_IDLE;
         width_q     <= 24'd0;
         cnt_q       <= 24'd0;
         len_q       <= 32'd0;
         trig_prev_q <= 1'b0;
         echo_q      <= 1'b0;
         busy_q      <= 1'b0;
         acc_q       <= 1'b0;
         rej_q       <= 1'b0;
      end else begin
         trig_prev_q <= trig_s;
         acc_q       <= 1'b0;
         rej_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               echo_q <= 1'b0;
               cnt_q  <= 24'd0;
               if (trig_fall) begin
                  width_q <= 24'd0;
                  if (width_q >= LP_TRIG_MIN) begin
                     acc_q   <= 1'b1;
                     len_q   <= len_d;
                     busy_q  <= 1'b1;
                     state_q <= S_BURST_DELAY;
                  end else begin
                     rej_q   <= 1'b1;
                  end
               end else if (trig_s) begin
                  width_q <= width_d;
               end
            end

            S_BURST_DELAY: begin
               width_q <= 24'd0;
               if (cnt_q == LP_BURST - 24'd1) begin
                  cnt_q   <= 24'd0;
                  echo_q  <= 1'b1;
                  state_q <= S_ECHO_HIGH;
               end else begin
                  cnt_q   <= cnt_q + 24'd1;
               end
            end

            S_ECHO_HIGH: begin
               width_q <= 24'd0;
               if ({8'd0, cnt_q} == len_q - 32'd1) begin
                  cnt_q   <= 24'd0;
                  echo_q  <= 1'b0;
                  state_q <= S_HOLDOFF;
               end else begin
                  cnt_q   <= cnt_q + 24'd1;
               end
            end

            S_HOLDOFF: begin
               width_q <= 24'd0;
               echo_q  <= 1'b0;
               if (cnt_q == LP_HOLDOFF - 24'd1) begin
                  cnt_q   <= 24'd0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q   <= cnt_q + 24'd1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               width_q <= 24'd0;
               cnt_q   <= 24'd0;
               echo_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oEcho         = echo_q;
   assign bus.oBusy         = busy_q;
   assign bus.oTrigAccepted = acc_q;
   assign bus.oTrigRejected = rej_q;
endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed bench for the HC-SR04 emulator at 1 MHz (1 cycle/us) with shortened burst, no-echo and holdoff.
module tb_hcsr04_echo_emulator;
   localparam int CLK_HZ   = 1_000_000;
   localparam int MIN_TRIG = 10;
   localparam int BURST    = 20;
   localparam int MAX_CM   = 10;
   localparam int NO_ECHO  = 700;
   localparam int HOLDOFF  = 100;

   logic iClk  = 1'b0;
   logic iRstn = 1'b0;

   hcsr04_echo_emulator_if bus();

   hcsr04_echo_emulator #(
      .P_SYS_CLK_HZ  (CLK_HZ),
      .P_MIN_TRIG_US (MIN_TRIG),
      .P_BURST_US    (BURST),
      .P_MAX_CM      (MAX_CM),
      .P_NO_ECHO_US  (NO_ECHO),
      .P_HOLDOFF_US  (HOLDOFF)
   ) dut (
      .iClk  (iClk),
      .iRstn (iRstn),
      .bus   (bus)
   );

   always #5 iClk = ~iClk;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int acc_cnt = 0, rej_cnt = 0, both_cnt = 0, rise_cnt = 0, busy_hi = 0;
   int acc_cyc = 0, rise_cyc = 0, fall_cyc = 0, bfall_cyc = 0;
   logic echo_prev = 1'b0, busy_prev = 1'b0;

   always @(posedge iClk) cyc <= cyc + 1;

   always @(negedge iClk) begin
      if (bus.oTrigAccepted) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (bus.oTrigRejected) rej_cnt++;
      if (bus.oTrigAccepted && bus.oTrigRejected) both_cnt++;
      if (bus.oEcho && !echo_prev) begin
         rise_cnt++;
         rise_cyc = cyc;
      end
      if (!bus.oEcho && echo_prev) fall_cyc = cyc;
      if (!bus.oBusy && busy_prev) bfall_cyc = cyc;
      if (bus.oBusy) busy_hi++;
      echo_prev = bus.oEcho;
      busy_prev = bus.oBusy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_trig(input int hi);
      bus.iTrig = 1'b1;
      repeat (hi) @(negedge iClk);
      bus.iTrig = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      repeat (6) @(negedge iClk);
      for (int i = 0; i < 2000; i++) begin
         if (!bus.oBusy) break;
         @(negedge iClk);
      end
      check({tag, "_idle"}, {31'd0, bus.oBusy}, 32'd0);
      repeat (3) @(negedge iClk);
   endtask

   task automatic wait_echo(input string tag, input logic level);
      for (int i = 0; i < 1000; i++) begin
         if (bus.oEcho === level) break;
         @(negedge iClk);
      end
      check({tag, "_echo_wait"}, {31'd0, bus.oEcho}, {31'd0, level});
   endtask

   task automatic measure(input string tag, input logic [15:0] d, input int hi, input int exp_len);
      int acc0, rej0;
      acc0 = acc_cnt;
      rej0 = rej_cnt;
      bus.iDistanceCm = d;
      pulse_trig(hi);
      wait_idle(tag);
      check({tag, "_acc"},   acc_cnt - acc0, 1);
      check({tag, "_rej"},   rej_cnt - rej0, 0);
      check({tag, "_burst"}, rise_cyc - acc_cyc, BURST);
      check({tag, "_width"}, fall_cyc - rise_cyc, exp_len);
      check({tag, "_hold"},  bfall_cyc - fall_cyc, HOLDOFF);
   endtask

   initial begin
      int acc0, rej0, rise0, busy0;
      bus.iTrig = 1'b0;
      bus.iDistanceCm = 16'd0;
      repeat (3) @(negedge iClk);
      check("rst_echo", {31'd0, bus.oEcho}, 0);
      check("rst_busy", {31'd0, bus.oBusy}, 0);
      check("rst_acc",  {31'd0, bus.oTrigAccepted}, 0);
      check("rst_rej",  {31'd0, bus.oTrigRejected}, 0);
      iRstn = 1'b1;
      repeat (3) @(negedge iClk);

      measure("d5", 16'd5, 12, 290);

      // One cycle short of the minimum width.
      acc0 = acc_cnt; rej0 = rej_cnt; rise0 = rise_cnt; busy0 = busy_hi;
      bus.iDistanceCm = 16'd5;
      pulse_trig(9);
      repeat (20) @(negedge iClk);
      check("short_rej",  rej_cnt - rej0, 1);
      check("short_acc",  acc_cnt - acc0, 0);
      check("short_echo", rise_cnt - rise0, 0);
      check("short_busy", busy_hi - busy0, 0);

      measure("min_max", 16'd10, 10, 580);
      measure("d0",      16'd0,  12, NO_ECHO);
      measure("d11",     16'd11, 12, NO_ECHO);

      // Triggers during ECHO_HIGH and HOLDOFF are ignored.
      acc0 = acc_cnt; rej0 = rej_cnt;
      bus.iDistanceCm = 16'd3;
      pulse_trig(12);
      wait_echo("ign_rise", 1'b1);
      pulse_trig(12);
      wait_echo("ign_fall", 1'b0);
      pulse_trig(12);
      wait_idle("ign");
      check("ign_acc",   acc_cnt - acc0, 1);
      check("ign_rej",   rej_cnt - rej0, 0);
      check("ign_width", fall_cyc - rise_cyc, 174);
      check("ign_hold",  bfall_cyc - fall_cyc, HOLDOFF);
      measure("after_hold", 16'd3, 12, 174);

      // Distance change after acceptance has no effect.
      bus.iDistanceCm = 16'd5;
      pulse_trig(12);
      for (int i = 0; i < 10; i++) begin
         if (bus.oTrigAccepted) break;
         @(negedge iClk);
      end
      check("chg_acc_seen", {31'd0, bus.oTrigAccepted}, 1);
      bus.iDistanceCm = 16'd9;
      wait_idle("chg");
      check("chg_width", fall_cyc - rise_cyc, 290);
      check("chg_burst", rise_cyc - acc_cyc, BURST);

      // Asynchronous reset in the middle of an echo.
      bus.iDistanceCm = 16'd10;
      pulse_trig(12);
      wait_echo("rst_mid_rise", 1'b1);
      repeat (50) @(negedge iClk);
      #2 iRstn = 1'b0;
      #1;
      check("rst_mid_echo", {31'd0, bus.oEcho}, 0);
      check("rst_mid_busy", {31'd0, bus.oBusy}, 0);
      repeat (3) @(negedge iClk);
      iRstn = 1'b1;
      repeat (3) @(negedge iClk);
      measure("post_rst", 16'd2, 12, 116);

      check("exclusive", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
